hybrid_sigmoid: RTL and testbench

//  Hybrid (piecewise-linear, shift-only) sigmoid approximation for NN activation datapaths.

---
 rtl/hybrid_pkg.sv | 36 +++
 rtl/hybrid_pwl_seg.sv | 35 +++
 rtl/hybrid_sigmoid.sv | 71 +++++++
 tb/tb_hybrid_sigmoid.sv | 96 +++++++++
 4 files changed

// File: rtl/hybrid_pkg.sv
// Constants for the shift-only piecewise-linear sigmoid: word sizes, breakpoints, intercepts, slope shifts.
// Breakpoints are in input LSB units (2^-F); intercepts and results are in output LSB units (2^-W_OUT).
package hybrid_pkg;

    localparam int W_IN  = 8;
    localparam int W_OUT = 9;
    localparam int IN_I  = 3;
    localparam int F     = W_IN - IN_I;
    localparam int SH    = W_OUT - F;
    localparam int W_A   = W_IN + 1;
    localparam int W_Y   = W_A + SH + 2;

    typedef enum logic [1:0] {
        SEG_LO  = 2'd0,
        SEG_MID = 2'd1,
        SEG_HI  = 2'd2,
        SEG_SAT = 2'd3
    } seg_t;

    // |x| is held in W_A bits so that the most negative input still has a representable magnitude
    localparam logic [W_A-1:0] BP_1   = W_A'(1)  << F;
    localparam logic [W_A-1:0] BP_2   = W_A'(19) << (F - 3);
    localparam logic [W_A-1:0] BP_3   = W_A'(5)  << F;

    localparam logic [W_Y-1:0] ONE_Y  = W_Y'(1)  << W_OUT;
    localparam logic [W_Y-1:0] INT_LO  = W_Y'(1)  << (W_OUT - 1);
    localparam logic [W_Y-1:0] INT_MID = W_Y'(5)  << (W_OUT - 3);
    localparam logic [W_Y-1:0] INT_HI  = W_Y'(27) << (W_OUT - 5);

    localparam int SLOPE_LO_SH  = 2;
    localparam int SLOPE_MID_SH = 3;
    localparam int SLOPE_HI_SH  = 5;

    localparam logic [W_OUT-1:0] SAT_MAX = {W_OUT{1'b1}};

endpackage

// File: rtl/hybrid_pwl_seg.sv
// Combinational |x| -> y: picks the segment and evaluates intercept + shifted magnitude.
// Boundary values fall into the upper segment; the shallowest slope truncates toward zero.
module hybrid_pwl_seg
    import hybrid_pkg::*;
(
    input  logic [W_A-1:0] i_a,
    output logic [W_Y-1:0] o_y
);

    logic [W_Y-1:0] w_a_al;
    seg_t           w_seg;

    assign w_a_al = W_Y'(i_a) << SH;

    always_comb begin
        w_seg = SEG_SAT;
        if (i_a < BP_1)
            w_seg = SEG_LO;
        else if (i_a < BP_2)
            w_seg = SEG_MID;
        else if (i_a < BP_3)
            w_seg = SEG_HI;
    end

    always_comb begin
        o_y = ONE_Y;
        case (w_seg)
            SEG_LO:  o_y = INT_LO  + (w_a_al >> SLOPE_LO_SH);
            SEG_MID: o_y = INT_MID + (w_a_al >> SLOPE_MID_SH);
            SEG_HI:  o_y = INT_HI  + (w_a_al >> SLOPE_HI_SH);
            default: o_y = ONE_Y;
        endcase
    end

endmodule

// File: rtl/hybrid_sigmoid.sv
// Sigmoid approximation top: abs/sign, segment evaluation, symmetry fold, saturation, registered output.
// Latency 1 cycle; HYBRID_PIPE_EN adds a register after segment evaluation (latency 2). No backpressure.
module hybrid_sigmoid
    import hybrid_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic [W_IN-1:0]  in,
    output logic [W_OUT-1:0] out
);

    logic                  w_neg;
    logic [W_A-1:0]        w_a;
    logic [W_Y-1:0]        w_y;
    logic                  w_neg_s;
    logic [W_Y-1:0]        w_y_s;
    logic signed [W_Y:0]   w_res;
    logic [W_OUT-1:0]      w_sat;
    logic [W_OUT-1:0]      r_out;

    assign w_neg = in[W_IN-1];
    assign w_a   = w_neg ? (~{in[W_IN-1], in} + W_A'(1)) : {1'b0, in};

    hybrid_pwl_seg u_seg (
        .i_a (w_a),
        .o_y (w_y)
    );

`ifdef HYBRID_PIPE_EN
    logic           r_neg;
    logic [W_Y-1:0] r_y;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_neg <= 1'b0;
            r_y   <= '0;
        end else begin
            r_neg <= w_neg;
            r_y   <= w_y;
        end
    end

    assign w_neg_s = r_neg;
    assign w_y_s   = r_y;
`else
    assign w_neg_s = w_neg;
    assign w_y_s   = w_y;
`endif

    // Negative inputs use sigmoid(-x) = 1 - sigmoid(x)
    assign w_res = w_neg_s ? ($signed({1'b0, ONE_Y}) - $signed({1'b0, w_y_s}))
                           : $signed({1'b0, w_y_s});

    always_comb begin
        w_sat = w_res[W_OUT-1:0];
        if (w_res < 0)
            w_sat = '0;
        else if (w_res > $signed({{(W_Y+1-W_OUT){1'b0}}, SAT_MAX}))
            w_sat = SAT_MAX;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            r_out <= '0;
        else
            r_out <= w_sat;
    end

    assign out = r_out;

endmodule

// File: tb/tb_hybrid_sigmoid.sv
// Directed-vector bench for hybrid_sigmoid; expected values hand-computed from the segment table.
// Honours HYBRID_PIPE_EN by waiting one extra cycle per result.
module tb_hybrid_sigmoid;

`ifdef HYBRID_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] in_dat;
    logic [8:0] out_dat;

    int checks = 0;
    int errors = 0;

    hybrid_sigmoid dut (
        .clock  (clk),
        .resetn (rst_n),
        .in     (in_dat),
        .out    (out_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive on a falling edge, then look at the output LAT rising edges later
    task automatic apply(input string tag, input logic [7:0] x, input logic [8:0] exp);
        in_dat = x;
        repeat (LAT) @(negedge clk);
        chk(tag, out_dat, exp);
    endtask

    logic [7:0] b2b_in  [3];
    logic [8:0] b2b_exp [3];

    initial begin
        rst_n  = 1'b0;
        in_dat = 8'h55;
        @(negedge clk);
        chk("reset", out_dat, 9'd0);
        repeat (LAT) @(negedge clk);
        chk("reset_hold", out_dat, 9'd0);

        rst_n = 1'b1;
        apply("pos_0p53",  8'b000_10001, 9'd324);
        apply("pos_1p53",  8'b001_10001, 9'd418);
        apply("pos_0p09",  8'b000_00011, 9'd268);
        apply("zero",      8'b000_00000, 9'd256);
        apply("neg_1p0",   8'b111_00000, 9'd128);
        apply("neg_4p0",   8'h80,        9'd16);
        apply("max_pos",   8'h7F,        9'd495);
        apply("bp2_below", 8'b010_01011, 9'd470);
        apply("bp2_at",    8'b010_01100, 9'd470);
        apply("bp1_below", 8'b000_11111, 9'd380);
        apply("bp1_at",    8'b001_00000, 9'd384);
        apply("neg_0p53",  8'b111_01111, 9'd188);
        apply("neg_2p375", 8'b101_10100, 9'd42);

        b2b_in[0] = 8'b000_10001; b2b_exp[0] = 9'd324;
        b2b_in[1] = 8'b111_00000; b2b_exp[1] = 9'd128;
        b2b_in[2] = 8'h7F;        b2b_exp[2] = 9'd495;
        for (int s = 0; s < 3 + LAT; s++) begin
            if (s >= LAT)
                chk($sformatf("b2b_%0d", s - LAT), out_dat, b2b_exp[s - LAT]);
            if (s < 3)
                in_dat = b2b_in[s];
            @(negedge clk);
        end

        in_dat = 8'h7F;
        @(negedge clk);
        rst_n  = 1'b0;
        in_dat = 8'b001_10001;
        @(negedge clk);
        chk("midreset", out_dat, 9'd0);
        rst_n  = 1'b1;
        in_dat = 8'b000_00011;
        repeat (LAT) @(negedge clk);
        chk("after_reset", out_dat, 9'd268);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
